// File: rtl/burst_mem_pkg.sv
// Shared types and helpers for the burst memory arbiter.
//   idx_w()      : channel-index width for a given channel count (min 1 bit)
//   burst_req_t  : one requester's burst command at the default widths
//   state_t      : arbiter state (IDLE = free to arbitrate, BUSY = burst owned)
package burst_mem_pkg;

    localparam int NUM_CH_DEF  = 5;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 64;
    localparam int MASK_W_DEF  = DATA_W_DEF / 8;
    localparam int BURST_W_DEF = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_IDX_W_DEF = idx_w(NUM_CH_DEF);

    typedef struct packed {
        logic                   rd;
        logic                   wr;
        logic [ADDR_W_DEF-1:0]  addr;
        logic [MASK_W_DEF-1:0]  mask;
        logic [DATA_W_DEF-1:0]  din;
        logic [BURST_W_DEF-1:0] burst_len;
    } burst_req_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/burst_mem_arbiter_rr_rr_priority_encoder.sv
// Combinational priority encoder with optional rotating start point.
//   req   in  N      active requests
//   ptr   in  IDX_W  search start when mode=1
//   mode  in  1      1 = search ptr, ptr+1 ... (wrapping), 0 = lowest index first
//   gnt   out N      one-hot winner, all zeros when no request
//   idx   out IDX_W  binary index of the winner (0 when no request)
module rr_priority_encoder
    import burst_mem_pkg::*;
#(
    parameter int N     = 5,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = mode ? IDX_W'((int'(ptr) + k) % N) : IDX_W'(k);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/burst_mem_arbiter_rr.sv
// N-channel burst memory arbiter. Selects one requester (fixed priority or
// round-robin), routes its command to the shared memory port and holds that
// grant from acceptance until out_burst_done. A watchdog aborts a burst that
// shows no out_valid / out_burst_done activity for TIMEOUT busy cycles.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   in_rd/in_wr/in_addr/in_mask/
//   in_din/in_burst_len          per-channel commands (channel i in slice i)
//   in_dout                      read data broadcast to every channel
//   in_wait_n/in_valid/
//   in_burst_done                per-channel handshake, gated by the grant
//   out_*                        shared memory port
//   grant                        one-hot chosen channel (combinational)
//   busy                         burst in progress (registered)
//   timeout_err                  one-cycle pulse on watchdog abort
module burst_mem_arbiter_rr
    import burst_mem_pkg::*;
#(
    parameter int NUM_CH      = 5,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int MASK_W      = DATA_W / 8,
    parameter int BURST_W     = 8,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 1023
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         in_rd,
    input  logic [NUM_CH-1:0]         in_wr,
    input  logic [NUM_CH*ADDR_W-1:0]  in_addr,
    input  logic [NUM_CH*MASK_W-1:0]  in_mask,
    input  logic [NUM_CH*DATA_W-1:0]  in_din,
    input  logic [NUM_CH*BURST_W-1:0] in_burst_len,
    output logic [DATA_W-1:0]         in_dout,
    output logic [NUM_CH-1:0]         in_wait_n,
    output logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_burst_done,
    output logic                      out_rd,
    output logic                      out_wr,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [MASK_W-1:0]         out_mask,
    output logic [DATA_W-1:0]         out_din,
    output logic [BURST_W-1:0]        out_burst_len,
    input  logic [DATA_W-1:0]         out_dout,
    input  logic                      out_wait_n,
    input  logic                      out_valid,
    input  logic                      out_burst_done,
    output logic [NUM_CH-1:0]         grant,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = idx_w(NUM_CH);
    // Counter just wide enough to reach TIMEOUT; a 1-bit stub when disabled.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                timeout_err_q, timeout_err_d;

    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   candidate;
    logic [IDX_W-1:0]    cand_idx;
    logic [IDX_W-1:0]    next_ptr;
    logic [NUM_CH-1:0]   chosen;
    logic                rr_mode;
    logic                accept;
    logic                wd_expire;

    assign req     = in_rd | in_wr;
    assign rr_mode = (ROUND_ROBIN != 0);

    rr_priority_encoder #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_enc (
        .req  (req),
        .ptr  (rr_ptr_q),
        .mode (rr_mode),
        .gnt  (candidate),
        .idx  (cand_idx)
    );

    assign busy        = (state_q == BUSY);
    assign timeout_err = timeout_err_q;
    // While a burst is owned the grant is frozen; new requests are ignored.
    assign chosen      = busy ? grant_q : candidate;
    assign grant       = chosen;

    // AND-OR mux: chosen is one-hot or zero, so zero selects all-zero fields.
    always_comb begin
        out_rd        = 1'b0;
        out_wr        = 1'b0;
        out_addr      = '0;
        out_mask      = '0;
        out_din       = '0;
        out_burst_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chosen[i]) begin
                out_rd        = out_rd | in_rd[i];
                out_wr        = out_wr | in_wr[i];
                out_addr      = out_addr | in_addr[i*ADDR_W +: ADDR_W];
                out_mask      = out_mask | in_mask[i*MASK_W +: MASK_W];
                out_din       = out_din | in_din[i*DATA_W +: DATA_W];
                out_burst_len = out_burst_len | in_burst_len[i*BURST_W +: BURST_W];
            end
        end
    end

    assign in_dout = out_dout;

    // With nothing chosen every channel sees the memory's wait_n, so an idle
    // requester can observe readiness before it is selected.
    assign in_wait_n     = {NUM_CH{out_wait_n}} & (chosen == '0 ? {NUM_CH{1'b1}} : chosen);
    assign in_valid      = chosen & {NUM_CH{out_valid}};
    assign in_burst_done = chosen & {NUM_CH{out_burst_done}};

    // A done seen while idle belongs to no burst and blocks acceptance.
    assign accept    = (out_rd | out_wr) & out_wait_n & ~out_burst_done;
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_MAX);
    assign next_ptr  = (cand_idx == IDX_W'(NUM_CH - 1)) ? '0 : cand_idx + 1'b1;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = BUSY;
                    grant_d  = candidate;
                    wd_cnt_d = '0;
                    if (rr_mode) rr_ptr_d = next_ptr;
                end else if (out_valid || out_burst_done) begin
                    wd_cnt_d = '0;
                end
            end
            BUSY: begin
                // Done takes precedence over a same-cycle watchdog expiry.
                if (out_burst_done) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    wd_cnt_d = '0;
                end else if (wd_expire) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    wd_cnt_d      = '0;
                    timeout_err_d = 1'b1;
                end else if (out_valid) begin
                    wd_cnt_d = '0;
                end else if (wd_cnt_q != WD_MAX) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_burst_mem_arbiter_rr.sv
// Directed bench: a fixed-priority instance and a round-robin instance
// (TIMEOUT=15) share one stimulus; each scenario checks the instance it targets.
module tb_burst_mem_arbiter_rr;

    localparam int NUM_CH  = 5;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int MASK_W  = 8;
    localparam int BURST_W = 8;

    logic                      clock;
    logic                      reset;
    logic [NUM_CH-1:0]         in_rd, in_wr;
    logic [NUM_CH*ADDR_W-1:0]  in_addr;
    logic [NUM_CH*MASK_W-1:0]  in_mask;
    logic [NUM_CH*DATA_W-1:0]  in_din;
    logic [NUM_CH*BURST_W-1:0] in_burst_len;
    logic [DATA_W-1:0]         out_dout;
    logic                      out_wait_n, out_valid, out_burst_done;

    logic [DATA_W-1:0]  in_dout_fp, in_dout_rr;
    logic [NUM_CH-1:0]  in_wait_n_fp, in_wait_n_rr, in_valid_fp, in_valid_rr;
    logic [NUM_CH-1:0]  in_burst_done_fp, in_burst_done_rr, grant_fp, grant_rr;
    logic               out_rd_fp, out_rd_rr, out_wr_fp, out_wr_rr;
    logic [ADDR_W-1:0]  out_addr_fp, out_addr_rr;
    logic [MASK_W-1:0]  out_mask_fp, out_mask_rr;
    logic [DATA_W-1:0]  out_din_fp, out_din_rr;
    logic [BURST_W-1:0] out_burst_len_fp, out_burst_len_rr;
    logic               busy_fp, busy_rr, to_fp, to_rr;

    int n_chk  = 0;
    int n_pass = 0;

    burst_mem_arbiter_rr #(.NUM_CH(NUM_CH), .ROUND_ROBIN(0), .TIMEOUT(1023)) dut_fp (
        .clock(clock), .reset(reset),
        .in_rd(in_rd), .in_wr(in_wr), .in_addr(in_addr), .in_mask(in_mask),
        .in_din(in_din), .in_burst_len(in_burst_len),
        .in_dout(in_dout_fp), .in_wait_n(in_wait_n_fp), .in_valid(in_valid_fp),
        .in_burst_done(in_burst_done_fp),
        .out_rd(out_rd_fp), .out_wr(out_wr_fp), .out_addr(out_addr_fp),
        .out_mask(out_mask_fp), .out_din(out_din_fp), .out_burst_len(out_burst_len_fp),
        .out_dout(out_dout), .out_wait_n(out_wait_n), .out_valid(out_valid),
        .out_burst_done(out_burst_done),
        .grant(grant_fp), .busy(busy_fp), .timeout_err(to_fp)
    );

    burst_mem_arbiter_rr #(.NUM_CH(NUM_CH), .ROUND_ROBIN(1), .TIMEOUT(15)) dut_rr (
        .clock(clock), .reset(reset),
        .in_rd(in_rd), .in_wr(in_wr), .in_addr(in_addr), .in_mask(in_mask),
        .in_din(in_din), .in_burst_len(in_burst_len),
        .in_dout(in_dout_rr), .in_wait_n(in_wait_n_rr), .in_valid(in_valid_rr),
        .in_burst_done(in_burst_done_rr),
        .out_rd(out_rd_rr), .out_wr(out_wr_rr), .out_addr(out_addr_rr),
        .out_mask(out_mask_rr), .out_din(out_din_rr), .out_burst_len(out_burst_len_rr),
        .out_dout(out_dout), .out_wait_n(out_wait_n), .out_valid(out_valid),
        .out_burst_done(out_burst_done),
        .grant(grant_rr), .busy(busy_rr), .timeout_err(to_rr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [4:0] e;
        reset          = 1'b1;
        in_rd          = '0;
        in_wr          = '0;
        in_addr        = {32'h500, 32'h400, 32'h300, 32'h200, 32'h100};
        in_mask        = {8'hF4, 8'hF3, 8'hF2, 8'hF1, 8'hF0};
        in_din         = {64'hD4, 64'hD3, 64'hD2, 64'hD1, 64'hD0};
        in_burst_len   = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        out_dout       = 64'hCAFE_F00D_1234_5678;
        out_wait_n     = 1'b1;
        out_valid      = 1'b0;
        out_burst_done = 1'b0;
        step();
        step();
        chk("rst_busy_fp", 64'(busy_fp), 64'd0);
        chk("rst_busy_rr", 64'(busy_rr), 64'd0);
        chk("rst_to_rr", 64'(to_rr), 64'd0);
        chk("rst_grant_rr", 64'(grant_rr), 64'd0);
        reset = 1'b0;
        #1;

        // idle, no requests
        chk("idle_wait_n", 64'(in_wait_n_fp), 64'h1F);
        chk("idle_out_rd", 64'(out_rd_fp), 64'd0);
        chk("idle_out_wr", 64'(out_wr_fp), 64'd0);
        chk("idle_out_addr", 64'(out_addr_fp), 64'd0);
        chk("idle_dout", 64'(in_dout_fp), 64'hCAFE_F00D_1234_5678);

        // memory not ready: candidate shown but not taken
        out_wait_n = 1'b0;
        in_rd      = 5'b00100;
        #1;
        chk("nowait_grant", 64'(grant_rr), 64'h04);
        chk("nowait_wait_n", 64'(in_wait_n_fp), 64'd0);
        step();
        chk("nowait_busy_fp", 64'(busy_fp), 64'd0);
        chk("nowait_busy_rr", 64'(busy_rr), 64'd0);

        // fixed priority
        in_rd      = 5'b10110;
        out_wait_n = 1'b1;
        #1;
        chk("fp_grant", 64'(grant_fp), 64'h02);
        chk("fp_addr", 64'(out_addr_fp), 64'h200);
        chk("fp_rd", 64'(out_rd_fp), 64'd1);
        chk("fp_len", 64'(out_burst_len_fp), 64'd2);
        chk("fp_mask", 64'(out_mask_fp), 64'hF1);
        step();
        chk("fp_busy", 64'(busy_fp), 64'd1);
        in_rd     = 5'b10100;
        out_valid = 1'b1;
        #1;
        chk("fp_hold_grant", 64'(grant_fp), 64'h02);
        chk("fp_hold_addr", 64'(out_addr_fp), 64'h200);
        chk("fp_valid", 64'(in_valid_fp), 64'h02);
        step();
        out_valid      = 1'b0;
        out_burst_done = 1'b1;
        #1;
        chk("fp_done", 64'(in_burst_done_fp), 64'h02);
        step();
        out_burst_done = 1'b0;
        #1;
        chk("fp_rel_busy", 64'(busy_fp), 64'd0);
        chk("fp_next_grant", 64'(grant_fp), 64'h04);
        chk("fp_next_addr", 64'(out_addr_fp), 64'h300);
        step();
        chk("fp_next_busy", 64'(busy_fp), 64'd1);
        in_rd          = '0;
        out_burst_done = 1'b1;
        step();
        out_burst_done = 1'b0;
        step();

        // round robin from reset, all channels requesting
        reset = 1'b1;
        in_rd = 5'b11111;
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            e = 5'(1 << (k % 5));
            #1;
            chk("rr_grant", 64'(grant_rr), 64'(e));
            step();
            chk("rr_busy", 64'(busy_rr), 64'd1);
            out_valid = 1'b1;
            #1;
            chk("rr_valid", 64'(in_valid_rr), 64'(e));
            repeat (4) step();
            out_valid      = 1'b0;
            out_burst_done = 1'b1;
            step();
            out_burst_done = 1'b0;
        end
        in_rd = '0;

        // busy lock: ch3 owns the port while ch0 asks
        in_rd        = 5'b01000;
        in_burst_len = {8'd5, 8'd16, 8'd3, 8'd2, 8'd1};
        #1;
        chk("lock_grant0", 64'(grant_rr), 64'h08);
        step();
        chk("lock_busy", 64'(busy_rr), 64'd1);
        in_wr = 5'b00001;
        #1;
        chk("lock_grant", 64'(grant_rr), 64'h08);
        chk("lock_wait_n", 64'(in_wait_n_rr), 64'h08);
        chk("lock_len", 64'(out_burst_len_rr), 64'd16);
        out_valid = 1'b1;
        #1;
        chk("lock_valid", 64'(in_valid_rr), 64'h08);
        step();
        out_valid      = 1'b0;
        out_burst_done = 1'b1;
        #1;
        chk("lock_wait_n_done", 64'(in_wait_n_rr), 64'h08);
        step();
        out_burst_done = 1'b0;
        #1;
        chk("lock_rel_busy", 64'(busy_rr), 64'd0);
        chk("lock_rel_wait_n", 64'(in_wait_n_rr), 64'h01);
        chk("lock_rel_grant", 64'(grant_rr), 64'h01);
        in_rd = '0;
        in_wr = '0;
        step();

        // watchdog abort
        in_rd = 5'b00100;
        #1;
        chk("wd_grant", 64'(grant_rr), 64'h04);
        step();
        in_rd = '0;
        repeat (15) step();
        chk("wd_busy_hold", 64'(busy_rr), 64'd1);
        chk("wd_to_low", 64'(to_rr), 64'd0);
        step();
        chk("wd_abort_busy", 64'(busy_rr), 64'd0);
        chk("wd_to_pulse", 64'(to_rr), 64'd1);
        chk("wd_no_done", 64'(in_burst_done_rr), 64'd0);
        step();
        chk("wd_to_end", 64'(to_rr), 64'd0);

        // done on the expiry cycle wins
        in_rd = 5'b00100;
        #1;
        chk("wd2_grant", 64'(grant_rr), 64'h04);
        step();
        in_rd = '0;
        repeat (15) step();
        out_burst_done = 1'b1;
        #1;
        chk("wd2_done", 64'(in_burst_done_rr), 64'h04);
        step();
        out_burst_done = 1'b0;
        #1;
        chk("wd2_busy", 64'(busy_rr), 64'd0);
        chk("wd2_to", 64'(to_rr), 64'd0);
        step();
        chk("wd2_to_next", 64'(to_rr), 64'd0);

        // reset mid-burst
        in_rd = 5'b00100;
        step();
        chk("mrst_busy", 64'(busy_rr), 64'd1);
        chk("mrst_grant", 64'(grant_rr), 64'h04);
        in_rd = 5'b10010;
        reset = 1'b1;
        step();
        chk("mrst_busy_clr", 64'(busy_rr), 64'd0);
        chk("mrst_ptr_zero", 64'(grant_rr), 64'h02);
        chk("mrst_to", 64'(to_rr), 64'd0);
        reset = 1'b0;
        step();
        chk("mrst_regrant", 64'(grant_rr), 64'h02);
        chk("mrst_rebusy", 64'(busy_rr), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/burst_mem_arbiter_rr.md
Name: burst_mem_arbiter_rr

Overview:
- Parametrised N-channel burst memory arbiter. Multiplexes N burst-capable requesters onto one shared burst memory port (SDRAM/DDR controller side).
- Selectable fixed-priority or round-robin grant policy.
- Holds the grant from acceptance until the burst completes.
- Watchdog aborts a hung burst and flags an error, so one stalled client cannot lock the memory.

Parameters:
- NUM_CH, 5: number of requester channels (2..16).
- ADDR_W, 32: address width.
- DATA_W, 64: data width.
- MASK_W, DATA_W/8: byte-mask width.
- BURST_W, 8: burst-length field width.
- ROUND_ROBIN, 1: 1 = round-robin grant, 0 = fixed priority (channel 0 highest).
- TIMEOUT, 1023: maximum busy cycles without any out_valid or out_burst_done before abort. 0 disables the watchdog.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- in_rd  in  NUM_CH  per-channel read request
- in_wr  in  NUM_CH  per-channel write request
- in_addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies slice [i*ADDR_W +: ADDR_W]
- in_mask  in  NUM_CH*MASK_W  per-channel byte mask
- in_din  in  NUM_CH*DATA_W  per-channel write data
- in_burst_len  in  NUM_CH*BURST_W  per-channel burst length (beats)
- in_dout  out  DATA_W  read data, broadcast to all channels
- in_wait_n  out  NUM_CH  per-channel not-wait
- in_valid  out  NUM_CH  per-channel read data valid
- in_burst_done  out  NUM_CH  per-channel burst complete
- out_rd  out  1  memory read request
- out_wr  out  1  memory write request
- out_addr  out  ADDR_W  memory address
- out_mask  out  MASK_W  memory byte mask
- out_din  out  DATA_W  memory write data
- out_burst_len  out  BURST_W  memory burst length
- out_dout  in  DATA_W  memory read data
- out_wait_n  in  1  memory not-wait
- out_valid  in  1  memory read data valid
- out_burst_done  in  1  memory burst complete
- grant  out  NUM_CH  one-hot selected channel (combinational chosen vector)
- busy  out  1  burst in progress (registered)
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset is synchronous and active-high on reset; clock is clock.
- Reset values: busy=0, grant_reg=0, rr_ptr=0, wd_cnt=0, timeout_err=0.
- Reset mid-burst drops busy immediately. The memory side must also be reset.
- Request per channel: req[i] = in_rd[i] | in_wr[i].
- Candidate selection, ROUND_ROBIN=0: lowest-index active req.
- Candidate selection, ROUND_ROBIN=1: first active req at or after rr_ptr, searching rr_ptr, rr_ptr+1 … with modulo-NUM_CH wrap.
- No active request: candidate = all zeros.
- chosen = busy ? grant_reg : candidate. grant = chosen.
- Output mux: out_rd/out_wr/out_addr/out_mask/out_din/out_burst_len = fields of the chosen channel. All zeros when chosen == 0.
- Read data path: in_dout = out_dout, unconditionally.
- in_wait_n[i] = out_wait_n & (chosen==0 | chosen[i]).
- in_valid[i] = chosen[i] & out_valid.
- in_burst_done[i] = chosen[i] & out_burst_done.
- States:
  - IDLE (busy=0): accept = (out_rd|out_wr) & out_wait_n & ~out_burst_done.
  - On accept: grant_reg <= candidate, busy <= 1. If ROUND_ROBIN, rr_ptr <= (granted index + 1) mod NUM_CH.
  - out_burst_done in IDLE is ignored. No grant is taken that cycle.
  - BUSY (busy=1): grant frozen and input requests ignored for selection.
  - BUSY exits on out_burst_done: busy <= 0 next cycle. Re-arbitration is possible the cycle after done, not the same cycle.
- Watchdog:
  - wd_cnt clears on accept, out_valid or out_burst_done. Otherwise it increments while busy and saturates at TIMEOUT.
  - When busy and wd_cnt == TIMEOUT and TIMEOUT != 0: busy <= 0, timeout_err pulses 1 cycle, grant_reg <= 0. rr_ptr is unchanged by the abort.
  - The aborted channel receives no burst_done.
- Simultaneous out_burst_done and watchdog expiry: burst_done wins; timeout_err stays 0.
- Requester obligation: hold rd/wr and fields stable until wait_n is seen high. The arbiter adds zero latency on the combinational path.

Decomposition:
- Package burst_mem_pkg holds:
  - localparam helpers for channel index width, $clog2(NUM_CH).
  - Typedef of the burst request struct {rd, wr, addr, mask, din, burst_len} for default widths.
  - Typedef state_t {IDLE, BUSY}.
- One sub-module: rr_priority_encoder.
  - Inputs: req, ptr, mode.
  - Outputs: one-hot grant and binary index.
  - Purely combinational; unit-tested separately.
- Top level holds the registers, watchdog and mux.

Test Plan:
- Fixed priority (ROUND_ROBIN=0), in_rd=5'b10110, out_wait_n=1 -> grant=5'b00010 and busy=1 next cycle. out_addr = ch1 addr until out_burst_done. Then, with ch1 dropping its request, ch2 is granted next.
- Round-robin, all 5 channels hold rd continuously, each burst ends with out_burst_done after 4 out_valid beats -> grant sequence 0,1,2,3,4,0.
- Busy lock: ch3 granted with in_burst_len=8'd16; ch0 asserts wr mid-burst -> grant stays 5'b01000. in_wait_n[0]=0 until 1 cycle after done. in_valid only on bit 3.
- Idle wait_n: no requests, out_wait_n=1 -> in_wait_n=5'b11111, out_rd=out_wr=0, out_addr=0. out_wait_n=0 on accept cycle -> no grant, busy stays 0.
- Watchdog: TIMEOUT=15, grant ch2, no valid/done -> after 15 busy cycles busy=0 and timeout_err=1 for exactly 1 cycle. Variant: out_burst_done on the expiry cycle -> timeout_err=0.
- Reset mid-burst: assert reset while busy=1 with grant=5'b00100 -> next cycle busy=0, grant follows candidate, rr_ptr=0.
